// File: rtl/test_arith_int_pkg.sv
// test_arith_int_pkg
//   Shared definitions for the arithmetic self-test block: FSM state enum,
//   constant operands, expected results of every step and divider latency.
//   Optional LONG step is controlled in the top by TEST_ARITH_INT_LONG_EN.
package test_arith_int_pkg;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_ADD,
    ST_SUB,
    ST_MUL,
    ST_DIV_START,
    ST_DIV_WAIT,
    ST_DIV_CHK,
    ST_AND,
    ST_OR,
    ST_XOR,
    ST_SHL,
    ST_SRA,
    ST_SRL,
    ST_NEG,
    ST_CMP,
    ST_WRAP,
    ST_LONG,
    ST_DONE
  } state_e;

  localparam int DIV_LAT = 32;

  localparam logic signed [31:0] OP_A      = 32'sd100;
  localparam logic signed [31:0] OP_B      = -32'sd7;
  localparam logic signed [31:0] WRAP_OPND = 32'h7FFF_FFFF;

  localparam logic signed [31:0] EXP_ADD  = 32'sd93;
  localparam logic signed [31:0] EXP_SUB  = 32'sd107;
  localparam logic signed [31:0] EXP_MUL  = -32'sd700;
  localparam logic signed [31:0] EXP_QUO  = -32'sd14;
  localparam logic signed [31:0] EXP_REM  = 32'sd2;
  localparam logic signed [31:0] EXP_AND  = 32'sd96;
  localparam logic signed [31:0] EXP_OR   = -32'sd3;
  localparam logic signed [31:0] EXP_XOR  = -32'sd99;
  localparam logic signed [31:0] EXP_SHL  = 32'sd800;
  localparam logic signed [31:0] EXP_SRA  = -32'sd4;
  localparam logic signed [31:0] EXP_SRL  = 32'h7FFF_FFFC;
  localparam logic signed [31:0] EXP_NEG  = -32'sd100;
  localparam logic signed [31:0] EXP_CMP  = 32'sd1;
  localparam logic signed [31:0] EXP_WRAP = 32'h8000_0000;
  localparam logic signed [63:0] EXP_LONG = 64'sd2147483648;

endpackage

// File: rtl/test_arith_int_div.sv
// test_arith_int_div
//   Sequential signed radix-2 restoring divider. Operates on magnitudes and
//   fixes signs at the output: quotient negative when operand signs differ,
//   remainder takes the sign of the dividend (truncating division).
// Ports
//   clk, reset (async, active-low)
//   start     : load operands, results valid DIV_LAT cycles later
//   dividend, divisor : signed 32-bit operands
//   quotient, remainder : signed 32-bit results
//   valid     : results stable and correct
module test_arith_int_div
  import test_arith_int_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        valid
);

  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dmag_q, dmag_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic        valid_q, valid_d;

  logic [32:0] rem_sh;
  logic [32:0] diff;

  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    valid_d = valid_q;
    // Partial remainder shifted left with the next dividend bit from the
    // top of the quotient register.
    rem_sh  = {rem_q, quo_q[31]};
    diff    = rem_sh - {1'b0, dmag_q};
    if (start) begin
      cnt_d   = 6'(DIV_LAT);
      rem_d   = '0;
      quo_d   = dividend[31] ? -dividend : dividend;
      dmag_d  = divisor[31] ? -divisor : divisor;
      neg_q_d = dividend[31] ^ divisor[31];
      neg_r_d = dividend[31];
      valid_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 6'd1;
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_sh[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      if (cnt_q == 6'd1) valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      valid_q <= valid_d;
    end
  end

  assign quotient  = neg_q_q ? -quo_q : quo_q;
  assign remainder = neg_r_q ? -rem_q : rem_q;
  assign valid     = valid_q;

endmodule

// File: rtl/test_arith_int.sv
// test_arith_int
//   Arithmetic self-test: on test_req runs a fixed sequence of operations on
//   constant operands, writes each result into field ic (LONG writes lc) and
//   ANDs a sticky ok flag with the comparison against the stored expectation.
//   test_return reports ok when the run finishes.
// Configuration macro: TEST_ARITH_INT_LONG_EN adds the 64-bit LONG step
//   (busy 48 cycles instead of 47).
// Ports
//   clk, reset (async, active-low)
//   ic_in/ic_we/ic_out : 32-bit field, writable only while idle
//   lc_in/lc_we/lc_out : 64-bit field, writable only while idle
//   test_req (level), test_busy, test_return
module test_arith_int
  import test_arith_int_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ic_in,
  input  logic        ic_we,
  output logic [31:0] ic_out,
  input  logic [63:0] lc_in,
  input  logic        lc_we,
  output logic [63:0] lc_out,
  input  logic        test_req,
  output logic        test_busy,
  output logic        test_return
);

  state_e      state_q, state_d;
  logic [4:0]  wait_q, wait_d;
  logic [31:0] ic_q, ic_d;
  logic [63:0] lc_q, lc_d;
  logic        ok_q, ok_d;
  logic        ret_q, ret_d;
  logic        busy_q, busy_d;

  logic signed [31:0] res;
  logic signed [31:0] exp_val;
  logic               wr_ic;
  logic               div_start;
  logic [31:0]        div_quo;
  logic [31:0]        div_rem;
  logic               div_valid;
`ifdef TEST_ARITH_INT_LONG_EN
  logic signed [63:0] long_res;
  assign long_res = {{32{WRAP_OPND[31]}}, WRAP_OPND} + 64'sd1;
`endif

  assign div_start = (state_q == ST_DIV_START);

  test_arith_int_div u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (OP_A),
    .divisor   (OP_B),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // Step ALU: result and expectation for the current state.
  always_comb begin
    res     = '0;
    exp_val = '0;
    wr_ic   = 1'b1;
    case (state_q)
      ST_ADD:     begin res = OP_A + OP_B;  exp_val = EXP_ADD;  end
      ST_SUB:     begin res = OP_A - OP_B;  exp_val = EXP_SUB;  end
      ST_MUL:     begin res = OP_A * OP_B;  exp_val = EXP_MUL;  end
      ST_DIV_CHK: begin res = div_quo;      exp_val = EXP_QUO;  end
      ST_AND:     begin res = OP_A & OP_B;  exp_val = EXP_AND;  end
      ST_OR:      begin res = OP_A | OP_B;  exp_val = EXP_OR;   end
      ST_XOR:     begin res = OP_A ^ OP_B;  exp_val = EXP_XOR;  end
      ST_SHL:     begin res = OP_A <<< 3;   exp_val = EXP_SHL;  end
      ST_SRA:     begin res = OP_B >>> 1;   exp_val = EXP_SRA;  end
      ST_SRL:     begin res = OP_B >> 1;    exp_val = EXP_SRL;  end
      ST_NEG:     begin res = -OP_A;        exp_val = EXP_NEG;  end
      ST_CMP:     begin
        res     = {31'd0, (OP_A > OP_B) && (OP_B < 32'sd0)};
        exp_val = EXP_CMP;
      end
      ST_WRAP:    begin res = WRAP_OPND + 32'sd1; exp_val = EXP_WRAP; end
      default:    wr_ic = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ic_d    = ic_q;
    lc_d    = lc_q;
    ok_d    = ok_q;
    ret_d   = ret_q;

    if (wr_ic) begin
      ic_d = res;
      ok_d = ok_q & (res == exp_val);
    end

    case (state_q)
      ST_IDLE: begin
        if (ic_we) ic_d = ic_in;
        if (lc_we) lc_d = lc_in;
        if (test_req) begin
          state_d = ST_ADD;
          ok_d    = 1'b1;
          ret_d   = 1'b0;
        end
      end
      ST_ADD:       state_d = ST_SUB;
      ST_SUB:       state_d = ST_MUL;
      ST_MUL:       state_d = ST_DIV_START;
      ST_DIV_START: begin
        state_d = ST_DIV_WAIT;
        wait_d  = 5'(DIV_LAT - 1);
      end
      ST_DIV_WAIT: begin
        if (wait_q == '0) state_d = ST_DIV_CHK;
        else              wait_d  = wait_q - 5'd1;
      end
      ST_DIV_CHK: begin
        state_d = ST_AND;
        ok_d    = ok_q & div_valid & (div_quo == EXP_QUO) & (div_rem == EXP_REM);
      end
      ST_AND:       state_d = ST_OR;
      ST_OR:        state_d = ST_XOR;
      ST_XOR:       state_d = ST_SHL;
      ST_SHL:       state_d = ST_SRA;
      ST_SRA:       state_d = ST_SRL;
      ST_SRL:       state_d = ST_NEG;
      ST_NEG:       state_d = ST_CMP;
      ST_CMP:       state_d = ST_WRAP;
`ifdef TEST_ARITH_INT_LONG_EN
      ST_WRAP:      state_d = ST_LONG;
      ST_LONG: begin
        state_d = ST_DONE;
        lc_d    = long_res;
        ok_d    = ok_q & (long_res == EXP_LONG);
      end
`else
      ST_WRAP:      state_d = ST_DONE;
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
        ret_d   = ok_q;
      end
      default:      state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      ic_q    <= '0;
      lc_q    <= '0;
      ok_q    <= 1'b0;
      ret_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ic_q    <= ic_d;
      lc_q    <= lc_d;
      ok_q    <= ok_d;
      ret_q   <= ret_d;
      busy_q  <= busy_d;
    end
  end

  assign ic_out      = ic_q;
  assign lc_out      = lc_q;
  assign test_busy   = busy_q;
  assign test_return = ret_q;

endmodule

// File: tb/tb_test_arith_int.sv
// Bench for test_arith_int and its divider sub-module.
module tb_test_arith_int;

`ifdef TEST_ARITH_INT_LONG_EN
  localparam int BUSY_LEN = 48;
`else
  localparam int BUSY_LEN = 47;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ic_in;
  logic        ic_we;
  logic [31:0] ic_out;
  logic [63:0] lc_in;
  logic        lc_we;
  logic [63:0] lc_out;
  logic        test_req;
  logic        test_busy;
  logic        test_return;

  logic        d_start;
  logic [31:0] d_dividend;
  logic [31:0] d_divisor;
  logic [31:0] d_quo;
  logic [31:0] d_rem;
  logic        d_valid;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] lc_model;
  logic [31:0] m_ic_final;
  logic [63:0] m_lc_long;

  always #5 clk = ~clk;

  test_arith_int dut (
    .clk         (clk),
    .reset       (reset),
    .ic_in       (ic_in),
    .ic_we       (ic_we),
    .ic_out      (ic_out),
    .lc_in       (lc_in),
    .lc_we       (lc_we),
    .lc_out      (lc_out),
    .test_req    (test_req),
    .test_busy   (test_busy),
    .test_return (test_return)
  );

  test_arith_int_div u_div_iso (
    .clk       (clk),
    .reset     (reset),
    .start     (d_start),
    .dividend  (d_dividend),
    .divisor   (d_divisor),
    .quotient  (d_quo),
    .remainder (d_rem),
    .valid     (d_valid)
  );

  function automatic logic [63:0] exp_lc_after_run();
`ifdef TEST_ARITH_INT_LONG_EN
    return m_lc_long;
`else
    return lc_model;
`endif
  endfunction

  // Counts busy cycles from the current negedge until busy falls.
  task automatic count_busy(output int n);
    n = 0;
    while (test_busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ic_in = '0; ic_we = 1'b0; lc_in = '0; lc_we = 1'b0; test_req = 1'b0;
    d_start = 1'b0; d_dividend = '0; d_divisor = 32'd1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    lc_model = '0;
    @(negedge clk);
    checks++; if (ic_out !== 32'd0) begin failures++; $display("FAIL reset_ic got=%h exp=0", ic_out); end
    checks++; if (lc_out !== 64'd0) begin failures++; $display("FAIL reset_lc got=%h exp=0", lc_out); end
    checks++; if (test_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", test_busy); end
    checks++; if (test_return !== 1'b0) begin failures++; $display("FAIL reset_return got=%b exp=0", test_return); end
  endtask

  task automatic test_single_run();
    int n;
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
    checks++; if (test_busy !== 1'b1) begin failures++; $display("FAIL run_busy_rise got=%b exp=1", test_busy); end
    count_busy(n);
    checks++; if (n != BUSY_LEN) begin failures++; $display("FAIL run_busy_len got=%0d exp=%0d", n, BUSY_LEN); end
    checks++; if (test_return !== 1'b1) begin failures++; $display("FAIL run_return got=%b exp=1", test_return); end
    checks++; if (ic_out !== m_ic_final) begin failures++; $display("FAIL run_ic got=%h exp=%h", ic_out, m_ic_final); end
    checks++; if (lc_out !== exp_lc_after_run()) begin failures++; $display("FAIL run_lc got=%h exp=%h", lc_out, exp_lc_after_run()); end
    lc_model = lc_out === exp_lc_after_run() ? exp_lc_after_run() : lc_model;
  endtask

  task automatic test_field_write();
    logic [31:0] v;
    logic [63:0] w;
    int n;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 32'd5 : $urandom;
      ic_in = v; ic_we = 1'b1;
      @(negedge clk);
      ic_we = 1'b0;
      checks++; if (ic_out !== v) begin failures++; $display("FAIL idle_ic_write got=%h exp=%h", ic_out, v); end
      w = {$urandom, $urandom};
      lc_in = w; lc_we = 1'b1;
      @(negedge clk);
      lc_we = 1'b0;
      lc_model = w;
      checks++; if (lc_out !== w) begin failures++; $display("FAIL idle_lc_write got=%h exp=%h", lc_out, w); end
    end
    // Writes hammered throughout a run must have no effect.
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
    ic_we = 1'b1; lc_we = 1'b1;
    n = 0;
    while (test_busy === 1'b1 && n < 200) begin
      ic_in = 32'd5 + $urandom_range(0, 1000);
      lc_in = {$urandom, $urandom};
      n++;
      @(negedge clk);
    end
    ic_we = 1'b0; lc_we = 1'b0;
    checks++; if (n != BUSY_LEN) begin failures++; $display("FAIL busy_write_len got=%0d exp=%0d", n, BUSY_LEN); end
    checks++; if (ic_out !== m_ic_final) begin failures++; $display("FAIL busy_ic_ignored got=%h exp=%h", ic_out, m_ic_final); end
    checks++; if (lc_out !== exp_lc_after_run()) begin failures++; $display("FAIL busy_lc_ignored got=%h exp=%h", lc_out, exp_lc_after_run()); end
    checks++; if (test_return !== 1'b1) begin failures++; $display("FAIL busy_write_return got=%b exp=1", test_return); end
    lc_model = exp_lc_after_run();
  endtask

  task automatic test_back_to_back();
    int n;
    int g;
    test_req = 1'b1;
    for (int r = 0; r < 3; r++) begin
      g = 0;
      while (test_busy !== 1'b1 && g < 10) begin
        g++;
        @(negedge clk);
      end
      checks++; if (g != 1) begin failures++; $display("FAIL b2b_gap run=%0d got=%0d exp=1", r, g); end
      count_busy(n);
      checks++; if (n != BUSY_LEN) begin failures++; $display("FAIL b2b_len run=%0d got=%0d exp=%0d", r, n, BUSY_LEN); end
      checks++; if (test_return !== 1'b1) begin failures++; $display("FAIL b2b_return run=%0d got=%b exp=1", r, test_return); end
    end
    test_req = 1'b0;
    @(negedge clk);
    checks++; if (test_busy !== 1'b0) begin failures++; $display("FAIL b2b_stop got=%b exp=0", test_busy); end
  endtask

  task automatic test_reset_mid_run();
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (ic_out !== 32'd0) begin failures++; $display("FAIL midrst_ic got=%h exp=0", ic_out); end
    checks++; if (lc_out !== 64'd0) begin failures++; $display("FAIL midrst_lc got=%h exp=0", lc_out); end
    checks++; if (test_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", test_busy); end
    checks++; if (test_return !== 1'b0) begin failures++; $display("FAIL midrst_return got=%b exp=0", test_return); end
    lc_model = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_single_run();
  endtask

  task automatic test_divider();
    logic [31:0] dd;
    logic [31:0] dv;
    int q_m;
    int r_m;
    int lat;
    for (int i = 0; i < 12; i++) begin
      if (i == 0)      begin dd = 32'd100;           dv = -32'sd7; end
      else if (i == 1) begin dd = -32'sd100;         dv = 32'd7;   end
      else begin
        dd = $urandom;
        if ($urandom_range(0, 1) == 1) dv = $urandom;
        else dv = $urandom_range(1, 1000);
        if ($urandom_range(0, 1) == 1) dv = -dv;
        if (dv == 32'd0) dv = 32'd3;
        if (dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) dv = 32'd2;
      end
      q_m = int'(dd) / int'(dv);
      r_m = int'(dd) % int'(dv);
      d_dividend = dd; d_divisor = dv; d_start = 1'b1;
      @(negedge clk);
      d_start = 1'b0;
      lat = 0;
      while (d_valid !== 1'b1 && lat < 100) begin
        lat++;
        @(negedge clk);
      end
      checks++; if (lat != 32) begin failures++; $display("FAIL div_latency case=%0d got=%0d exp=32", i, lat); end
      checks++; if (d_quo !== 32'(q_m)) begin failures++; $display("FAIL div_quo case=%0d %0d/%0d got=%0d exp=%0d", i, int'(dd), int'(dv), int'(d_quo), q_m); end
      checks++; if (d_rem !== 32'(r_m)) begin failures++; $display("FAIL div_rem case=%0d %0d%%%0d got=%0d exp=%0d", i, int'(dd), int'(dv), int'(d_rem), r_m); end
    end
  endtask

  initial begin
    int a;
    int b;
    int wrap_opnd;
    int wrapped;
    a = 100;
    b = -7;
    wrap_opnd = 32'h7FFF_FFFF;
    wrapped   = wrap_opnd + 1;
    m_ic_final = wrapped;
    m_lc_long  = 64'(longint'(wrap_opnd) + 64'sd1);
    if (a / b != -14 || a % b != 2) $display("note: host arithmetic model disagrees with truncating division");

    test_reset();
    test_single_run();
    test_field_write();
    test_back_to_back();
    test_reset_mid_run();
    test_divider();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
